// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the round-robin stream arbiter.
package stream_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int PKT_CNT_W = 16;

    // Index after v in a ring of n entries.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/stream_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr,
// scanning upward and wrapping modulo N_REQ. Purely combinational.
module stream_rr_pick
    import stream_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic             any,
    output logic [SRC_W-1:0] idx
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;

    // Rotate so that bit 0 of req_rot is the request at ptr.
    assign req_dbl = {req, req};
    assign req_rot = N_REQ'(req_dbl >> ptr);

    // Lowest rotated position wins; map it back to an absolute index.
    always_comb begin
        int sum;
        sum = 0;
        any = |req_rot;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                sum = k;
            end
        end
        sum = sum + int'(ptr);
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end
        idx = SRC_W'(sum);
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready byte stream among N_REQ
// requesters. A grant is locked from first beat to the beat flagged last;
// the output passes through a single register stage.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ARB_IDLE | no grant; pick next requester cyclically from ptr
// ARB_BUSY | grant_q owns the output until its last beat is accepted
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int SRC_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        in_valid,
    output logic [N_REQ-1:0]        in_ready,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_last,
    output logic [SRC_W-1:0]        out_src,
    output logic                    busy,
    output logic [PKT_CNT_W-1:0]    pkt_count
);

    arb_state_t           state_q, state_d;
    logic [SRC_W-1:0]     grant_q, grant_d;
    logic [SRC_W-1:0]     ptr_q, ptr_d;
    logic                 out_valid_q;
    logic [DATA_W-1:0]    out_data_q;
    logic                 out_last_q;
    logic [SRC_W-1:0]     out_src_q;
    logic [PKT_CNT_W-1:0] pkt_count_q;

    logic                 can_load;
    logic                 accept;
    logic                 pkt_done;
    logic                 pick_any;
    logic [SRC_W-1:0]     pick_idx;
    logic [DATA_W-1:0]    in_beat [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_split
        assign in_beat[i] = in_data[i*DATA_W +: DATA_W];
    end

    stream_rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req (in_valid),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // The output register can take a new beat when empty or draining now.
    assign can_load = !out_valid_q || out_ready;

    // Next-state, grant/pointer update and per-requester ready.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        in_ready = '0;
        accept   = 1'b0;
        pkt_done = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                in_ready[grant_q] = can_load;
                accept            = in_valid[grant_q] && can_load;
                if (accept && in_last[grant_q]) begin
                    state_d  = ARB_IDLE;
                    ptr_d    = SRC_W'(wrap_inc(int'(grant_q), N_REQ));
                    pkt_done = 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output stage: load on accept, clear valid on a drain without reload.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_beat[grant_q];
            out_last_q  <= in_last[grant_q];
            out_src_q   <= grant_q;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completed-packet counter, wraps naturally at its width.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_count_q <= '0;
        end else if (pkt_done) begin
            pkt_count_q <= pkt_count_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;
    assign busy      = (state_q == ARB_BUSY);
    assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed bench for stream_rr_arbiter: per-requester beat queues, an
// output log, and hand-computed expectations.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int SW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [SW-1:0]   out_src;
    logic            busy;
    logic [15:0]     pkt_count;

    stream_rr_arbiter #(
        .N_REQ  (N),
        .DATA_W (DW),
        .SRC_W  (SW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .busy      (busy),
        .pkt_count (pkt_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [DW-1:0] q_data [N][16];
    logic          q_last [N][16];
    int            head   [N];
    int            tail   [N];
    logic          hold   [N];
    logic          fire   [N];

    logic [DW-1:0] lg_data [64];
    int            lg_src  [64];
    logic          lg_last [64];
    int            lg_cyc  [64];
    int            n_log;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int r, input logic [DW-1:0] d, input logic l);
        q_data[r][tail[r]] = d;
        q_last[r][tail[r]] = l;
        tail[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
                in_valid[i]          = !hold[i];
                in_data[i*DW +: DW]  = q_data[i][head[i]];
                in_last[i]           = q_last[i][head[i]];
            end else begin
                in_valid[i]          = 1'b0;
                in_data[i*DW +: DW]  = '0;
                in_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
            hold[i] = 1'b0;
            fire[i] = 1'b0;
        end
        n_log = 0;
        drive();
    endtask

    // Called at a falling edge: sample handshakes, clock once, update sources.
    task automatic step();
        #1;
        for (int i = 0; i < N; i++) fire[i] = in_valid[i] && in_ready[i];
        if (out_valid && out_ready && n_log < 64) begin
            lg_data[n_log] = out_data;
            lg_src[n_log]  = int'(out_src);
            lg_last[n_log] = out_last;
            lg_cyc[n_log]  = cyc;
            n_log++;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) if (fire[i]) head[i]++;
        drive();
        @(negedge clk);
    endtask

    function automatic bit quiet();
        bit q;
        q = !out_valid && !busy;
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) q = 1'b0;
        return q;
    endfunction

    task automatic wait_idle(input string tag, input int budget);
        int k;
        k = 0;
        while (!quiet() && k < budget) begin
            step();
            k++;
        end
        chk(tag, 32'(quiet()), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        clear_all();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pkt", 32'(pkt_count), 32'd0);
        chk("rst_oval", 32'(out_valid), 32'd0);
        chk("rst_irdy", 32'(in_ready), 32'd0);

        // Single requester, three-beat packet.
        push(1, 8'h11, 1'b0);
        push(1, 8'h22, 1'b0);
        push(1, 8'h33, 1'b1);
        drive();
        step();
        chk("sr_busy", 32'(busy), 32'd1);
        chk("sr_irdy", 32'(in_ready), 32'h2);
        step();
        chk("sr_v0", 32'(out_valid), 32'd1);
        chk("sr_d0", 32'(out_data), 32'h11);
        chk("sr_s0", 32'(out_src), 32'd1);
        chk("sr_l0", 32'(out_last), 32'd0);
        step();
        chk("sr_d1", 32'(out_data), 32'h22);
        chk("sr_l1", 32'(out_last), 32'd0);
        step();
        chk("sr_d2", 32'(out_data), 32'h33);
        chk("sr_l2", 32'(out_last), 32'd1);
        chk("sr_pkt", 32'(pkt_count), 32'd1);
        chk("sr_idle", 32'(busy), 32'd0);
        step();
        chk("sr_drain", 32'(out_valid), 32'd0);
        chk("sr_nlog", 32'(n_log), 32'd3);

        // Fairness: fresh reset so ptr starts at 0; two 2-beat packets each.
        reset = 1'b1;
        #1;
        reset = 1'b0;
        clear_all();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                for (int b = 0; b < 2; b++)
                    push(i, DW'(i*16 + p*2 + b), b == 1);
        drive();
        repeat (18) step();
        chk("rr_pkt6", 32'(pkt_count), 32'd6);
        wait_idle("rr_done", 100);
        chk("rr_pkt8", 32'(pkt_count), 32'd8);
        chk("rr_nlog", 32'(n_log), 32'd16);
        for (int k = 0; k < 16; k++) begin
            chk("rr_src", 32'(lg_src[k]), 32'((k/2) % 4));
            chk("rr_data", 32'(lg_data[k]), 32'(((k/2) % 4)*16 + ((k/2)/4)*2 + (k % 2)));
            chk("rr_last", 32'(lg_last[k]), 32'(k % 2));
        end
        for (int k = 1; k < 16; k++)
            chk("rr_gap", 32'(lg_cyc[k] - lg_cyc[k-1]), (k % 2 == 1) ? 32'd1 : 32'd2);

        // Backpressure mid-packet on requester 2 (ptr is 0 now).
        clear_all();
        for (int b = 0; b < 5; b++) push(2, DW'(8'hA0 + b), b == 4);
        drive();
        repeat (3) step();
        chk("bp_pre", 32'(out_data), 32'hA1);
        out_ready = 1'b0;
        repeat (5) begin
            step();
            chk("bp_irdy", 32'(in_ready), 32'd0);
            chk("bp_hold", 32'(out_data), 32'hA1);
            chk("bp_oval", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_idle("bp_done", 50);
        chk("bp_nlog", 32'(n_log), 32'd5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", 32'(lg_data[k]), 32'(8'hA0 + k));
            chk("bp_src", 32'(lg_src[k]), 32'd2);
            chk("bp_last", 32'(lg_last[k]), 32'(k == 4));
        end
        chk("bp_pkt", 32'(pkt_count), 32'd9);

        // Grant lock: requester 2 stalls mid-packet while requester 0 waits.
        clear_all();
        push(2, 8'hC0, 1'b0);
        push(2, 8'hC1, 1'b0);
        push(2, 8'hC2, 1'b1);
        drive();
        step();
        push(0, 8'hD0, 1'b0);
        push(0, 8'hD1, 1'b1);
        drive();
        hold[2] = 1'b1;
        step();
        repeat (3) begin
            step();
            chk("gl_busy", 32'(busy), 32'd1);
            chk("gl_irdy", 32'(in_ready), 32'h4);
        end
        hold[2] = 1'b0;
        drive();
        wait_idle("gl_done", 50);
        chk("gl_nlog", 32'(n_log), 32'd5);
        chk("gl_s0", 32'(lg_src[0]), 32'd2);
        chk("gl_d2", 32'(lg_data[2]), 32'hC2);
        chk("gl_l2", 32'(lg_last[2]), 32'd1);
        chk("gl_s3", 32'(lg_src[3]), 32'd0);
        chk("gl_d3", 32'(lg_data[3]), 32'hD0);
        chk("gl_d4", 32'(lg_data[4]), 32'hD1);
        chk("gl_pkt", 32'(pkt_count), 32'd11);

        // Counter wrap: jump the count to its top value, then finish one packet.
        clear_all();
        force dut.pkt_count_q = 16'hFFFF;
        #1;
        release dut.pkt_count_q;
        #1;
        chk("wr_pre", 32'(pkt_count), 32'hFFFF);
        push(1, 8'h5A, 1'b1);
        drive();
        wait_idle("wr_done", 20);
        chk("wr_pkt", 32'(pkt_count), 32'd0);
        chk("wr_nlog", 32'(n_log), 32'd1);
        chk("wr_data", 32'(lg_data[0]), 32'h5A);

        // Reset in the middle of a packet from requester 3.
        clear_all();
        for (int b = 0; b < 4; b++) push(3, DW'(8'h30 + b), b == 3);
        drive();
        repeat (3) step();
        chk("mr_pre", 32'(out_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mr_oval", 32'(out_valid), 32'd0);
        chk("mr_odat", 32'(out_data), 32'd0);
        chk("mr_osrc", 32'(out_src), 32'd0);
        chk("mr_olst", 32'(out_last), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_irdy", 32'(in_ready), 32'd0);
        clear_all();
        step();
        reset = 1'b0;
        push(0, 8'hE0, 1'b1);
        push(2, 8'hE2, 1'b1);
        drive();
        step();
        chk("mr_gnt", 32'(in_ready), 32'h1);
        wait_idle("mr_done", 30);
        chk("mr_nlog", 32'(n_log), 32'd2);
        chk("mr_s0", 32'(lg_src[0]), 32'd0);
        chk("mr_d0", 32'(lg_data[0]), 32'hE0);
        chk("mr_s1", 32'(lg_src[1]), 32'd2);
        chk("mr_pkt", 32'(pkt_count), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
